spike_event_fifo: RTL
=====================

Name: spike_event_fifo

Overview:
Buffers synapse-index spike events produced by TOP_snn (w_en / s_index_o) and returns full / almost_full backpressure to it. The consumer side is a valid/ready first-word-fall-through port feeding the downstream synaptic weight-fetch stage. Occupancy, a sticky overflow flag and a drop counter are exposed for debug and for bench checking.

Parameters:
IDX_W, 16, width of a synapse index; set equal to `SYNAPSE_INDEX at instantiation.
DEPTH, 64, number of entries; must be a power of two and at least 4.
AF_THRESH, 4, almost_full asserts when free slots <= AF_THRESH; legal range 1..DEPTH-1.

Ports:
clk  in  1  system clock, rising edge.
rstn  in  1  asynchronous reset, active low.
w_en  in  1  write strobe from the spike generator.
s_index_i  in  IDX_W  synapse index to store; sampled when w_en=1.
full  out  1  count == DEPTH.
almost_full  out  1  (DEPTH - count) <= AF_THRESH.
rd_valid  out  1  head entry is available (count != 0).
rd_ready  in  1  consumer accepts the head entry.
rd_index  out  IDX_W  head entry; stable while rd_valid=1 and rd_ready=0.
count  out  $clog2(DEPTH+1)  current occupancy.
overflow  out  1  sticky; set by any write attempted while full.
clr_overflow  in  1  synchronous clear of overflow.
drop_cnt  out  16  number of dropped writes; saturates at 16'hFFFF.

Behaviour:
- Reset: asynchronous on rstn=0. Takes effect immediately and overrides any operation in progress. wr_ptr=rd_ptr=0, count=0, overflow=0, drop_cnt=0, so rd_valid=0, full=0, almost_full=0. rd_index is 0 during reset. Storage contents are not reset and are don't-care.
- Storage: DEPTH x IDX_W register array with combinational read at rd_ptr. rd_index = mem[rd_ptr] when rd_valid=1, otherwise 0.
- Outputs full, almost_full and rd_valid are pure decodes of the registered count. No output has a combinational path from w_en or rd_ready.
- Write accept: wr_acc = w_en & ~full, evaluated with pre-edge state. On accept:
  - mem[wr_ptr] <= s_index_i;
  - wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- Read accept: rd_acc = rd_valid & rd_ready. On accept, rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
- count update: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither occur.
- Latency: a write accepted at edge N makes the entry visible on rd_index/rd_valid in the cycle after edge N. There is no write-to-read bypass within the same cycle.
- Full with simultaneous read: a write attempted while full is dropped even if rd_acc occurs in the same cycle. The read still proceeds, leaving count = DEPTH-1.
- Empty with simultaneous write: rd_ready is ignored (rd_valid=0) and the write proceeds.
- Drop: when w_en & full:
  - overflow <= 1;
  - drop_cnt <= drop_cnt+1, unless already 16'hFFFF.
- overflow clear: clr_overflow=1 clears overflow at the next edge. If a drop occurs in the same cycle, set wins and overflow stays 1. drop_cnt is cleared only by reset.
- Ordering: strict FIFO order. No entry is duplicated or lost except the dropped writes described above.
- rd_ready while rd_valid=0 has no effect.

Test Plan:
- Reset/idle: hold rstn=0 mid-run with 5 entries stored, then release → count=0, rd_valid=0, full=0, almost_full=0, overflow=0, drop_cnt=0.
- Single write latency: w_en=1 with s_index_i=16'h0123 for one cycle → rd_valid=1 and rd_index=16'h0123 in the following cycle; rd_ready=1 for one cycle → count=0.
- Fill and thresholds, DEPTH=64, AF_THRESH=4: write 0..59 → almost_full rises after the 60th write (count=60). Write 60..63 → full=1 at count=64. Three further writes → overflow=1, drop_cnt=3, count stays 64.
- Simultaneous read/write: while full, w_en=1 and rd_ready=1 → count=63, rd_index advances to 1, write dropped, drop_cnt+1. At count=10, both asserted for 20 cycles → count stays 10 and output order is preserved.
- Wrap-around: 200 random write/read cycles with random rd_ready; compare the output stream against a scoreboard queue → exact in-order match and no underflow.
- Overflow clear race: clr_overflow=1 in the same cycle as a dropped write → overflow stays 1. clr_overflow=1 alone on the next cycle → overflow=0 and drop_cnt unchanged.

Source files
------------

// File: rtl/spike_event_fifo.sv
// spike_event_fifo: synapse-index spike FIFO with full/almost_full backpressure,
// first-word-fall-through read port, sticky overflow and saturating drop counter.
module spike_event_fifo #(
  parameter int IDX_W     = 16,
  parameter int DEPTH     = 64,
  parameter int AF_THRESH = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         w_en,
  input  logic [IDX_W-1:0]             s_index_i,
  output logic                         full,
  output logic                         almost_full,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [IDX_W-1:0]             rd_index,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  input  logic                         clr_overflow,
  output logic [15:0]                  drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [IDX_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic             wr_acc, rd_acc, drop;
  // Status flags decode only the registered count, so no input reaches an output combinationally.
  assign full        = count_q == CW'(DEPTH);
  assign almost_full = (CW'(DEPTH) - count_q) <= CW'(AF_THRESH);
  assign rd_valid    = count_q != '0;
  assign rd_index    = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign drop_cnt    = drop_cnt_q;
  always_comb begin
    wr_acc     = w_en & ~full;
    rd_acc     = rd_valid & rd_ready;
    drop       = w_en & full;
    wr_ptr_d   = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = (wr_acc & ~rd_acc) ? count_q + CW'(1) :
                 (rd_acc & ~wr_acc) ? count_q - CW'(1) : count_q;
    overflow_d = drop | (overflow_q & ~clr_overflow);
    drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= s_index_i;
  end
endmodule
